// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional macro MULDIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow bypass CALC.
module muldiv_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  Start,
   input  logic [2:0]            MDControl,
   input  logic [DATA_WIDTH-1:0] SrcA,
   input  logic [DATA_WIDTH-1:0] SrcB,
   output logic                  Busy,
   output logic                  Done,
   output logic [DATA_WIDTH-1:0] MDResult,
   output logic                  ZeroFlag
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH) + 1;
   localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t         state_q, state_d;
   logic [2:0]     op_q, op_d;
   logic [W-1:0]   src_a_q, src_a_d;
   logic [W-1:0]   src_b_q, src_b_d;
   logic           a_neg_q, a_neg_d;
   logic           b_neg_q, b_neg_d;
   logic [W-1:0]   opb_q, opb_d;
   logic [2*W-1:0] acc_q, acc_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   result_q, result_d;

   logic           a_signed_in, b_signed_in;
   logic           a_neg_in, b_neg_in;
   logic [W-1:0]   a_abs_in, b_abs_in;
   logic [W:0]     mul_sum;
   logic [W:0]     div_shift, div_rem;
   logic           div_ge;
   logic [2*W-1:0] iter_next, prod_fix;
   logic [W-1:0]   quo_fix, rem_fix, final_res;

   // Divide by zero, or signed DIV/REM of the most negative value by -1.
   function automatic logic is_special(input logic [2:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
      logic ovf;
      ovf = (op[0] == 1'b0) && (a == MOST_NEG) && (b == '1);
      return op[2] && ((b == '0) || ovf);
   endfunction

   function automatic logic [W-1:0] special_result(input logic [2:0] op, input logic [W-1:0] a,
                                                   input logic [W-1:0] b);
      logic [W-1:0] r;
      if (b == '0) r = op[1] ? a : '1;
      else         r = op[1] ? '0 : MOST_NEG;
      return r;
   endfunction

   always_comb begin
      a_signed_in = MDControl inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
      b_signed_in = MDControl inside {3'b000, 3'b001, 3'b100, 3'b110};
      a_neg_in    = a_signed_in & SrcA[W-1];
      b_neg_in    = b_signed_in & SrcB[W-1];
      a_abs_in    = a_neg_in ? -SrcA : SrcA;
      b_abs_in    = b_neg_in ? -SrcB : SrcB;
   end

   // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
      div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
      div_ge    = (div_shift >= {1'b0, opb_q});
      div_rem   = div_ge ? (div_shift - {1'b0, opb_q}) : div_shift;
      if (op_q[2]) iter_next = {div_rem[W-1:0], acc_q[W-2:0], div_ge};
      else         iter_next = {mul_sum, acc_q[W-1:1]};

      prod_fix = (a_neg_q ^ b_neg_q) ? -iter_next : iter_next;
      quo_fix  = (a_neg_q ^ b_neg_q) ? -iter_next[W-1:0] : iter_next[W-1:0];
      rem_fix  = a_neg_q ? -iter_next[2*W-1:W] : iter_next[2*W-1:W];

      if (is_special(op_q, src_a_q, src_b_q)) final_res = special_result(op_q, src_a_q, src_b_q);
      else if (op_q[2])                        final_res = op_q[1] ? rem_fix : quo_fix;
      else if (op_q[1:0] == 2'b00)             final_res = prod_fix[W-1:0];
      else                                     final_res = prod_fix[2*W-1:W];
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      src_a_d  = src_a_q;
      src_b_d  = src_b_q;
      a_neg_d  = a_neg_q;
      b_neg_d  = b_neg_q;
      opb_d    = opb_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      case (state_q)
         CALC: begin
            acc_d = iter_next;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d  = DONE;
               result_d = final_res;
            end
         end
         default: begin
            state_d = IDLE;
            if (Start) begin
               op_d    = MDControl;
               src_a_d = SrcA;
               src_b_d = SrcB;
               a_neg_d = a_neg_in;
               b_neg_d = b_neg_in;
               if (MDControl[2]) begin
                  acc_d = {{W{1'b0}}, a_abs_in};
                  opb_d = b_abs_in;
               end else begin
                  acc_d = {{W{1'b0}}, b_abs_in};
                  opb_d = a_abs_in;
               end
               cnt_d   = CW'(W);
               state_d = CALC;
`ifdef MULDIV_FAST_SPECIAL_EN
               if (is_special(MDControl, SrcA, SrcB)) begin
                  cnt_d    = '0;
                  state_d  = DONE;
                  result_d = special_result(MDControl, SrcA, SrcB);
               end
`endif
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= '0;
         src_a_q  <= '0;
         src_b_q  <= '0;
         a_neg_q  <= 1'b0;
         b_neg_q  <= 1'b0;
         opb_q    <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         src_a_q  <= src_a_d;
         src_b_q  <= src_b_d;
         a_neg_q  <= a_neg_d;
         b_neg_q  <= b_neg_d;
         opb_q    <= opb_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign Busy     = (state_q == CALC);
   assign Done     = (state_q == DONE);
   assign MDResult = result_q;
   assign ZeroFlag = (result_q == '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner sequences, random vs. arithmetic model.
module tb_muldiv_unit;

   localparam int W = 32;
   localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
   localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;
   localparam logic [31:0] MINV = 32'h8000_0000;

   logic          clk = 1'b0;
   logic          rst;
   logic          Start;
   logic [2:0]    MDControl;
   logic [W-1:0]  SrcA, SrcB, MDResult;
   logic          Busy, Done, ZeroFlag;

   int total = 0;
   int bad   = 0;

   muldiv_unit #(.DATA_WIDTH(W)) dut (
      .clk(clk), .rst(rst), .Start(Start), .MDControl(MDControl),
      .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Done(Done),
      .MDResult(MDResult), .ZeroFlag(ZeroFlag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vt[16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Arithmetic reference built directly from the operation definitions.
   function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      longint      sa, sb, ua;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      p  = '0;
      case (op)
         OP_MUL:    begin p = sa * sb; return p[31:0]; end
         OP_MULH:   begin p = sa * sb; return p[63:32]; end
         OP_MULHSU: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
         OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         OP_DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
            p = sa / sb; return p[31:0];
         end
         OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         OP_REM: begin
            if (b == 0) return a;
            if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
            p = sa % sb; return p[31:0];
         end
         default:   begin p = ua; return (b == 0) ? a : a % b; end
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic spc;
      spc = op[2] && ((b == 0) || (!op[0] && a == MINV && b == 32'hFFFF_FFFF));
`ifdef MULDIV_FAST_SPECIAL_EN
      return spc ? 1 : W + 1;
`else
      return spc ? W + 1 : W + 1;
`endif
   endfunction

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return MINV;
         3: return 32'h1;
         4: return 32'h7FFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   // Called on a falling edge; returns on the falling edge of the Done cycle (lat = cycle index).
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output logic zf, output logic busy1);
      MDControl = op; SrcA = a; SrcB = b; Start = 1'b1;
      @(posedge clk); @(negedge clk);
      Start = 1'b0;
      lat   = 1;
      busy1 = Busy;
      while (!Done && lat < 200) begin
         @(posedge clk); @(negedge clk);
         lat++;
      end
      res = MDResult;
      zf  = ZeroFlag;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] res, res2, expv;
      logic        zf, busy1;
      int          lat, lat2, ndone, first;
      logic [2:0]  op;
      logic [31:0] a, b;

      vt[0]  = '{OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
      vt[1]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vt[2]  = '{OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000};
      vt[3]  = '{OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
      vt[4]  = '{OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
      vt[5]  = '{OP_DIVU,   32'd100,        32'd7,         32'd14};
      vt[6]  = '{OP_REMU,   32'd100,        32'd7,         32'd2};
      vt[7]  = '{OP_DIV,    MINV,           32'hFFFF_FFFF, MINV};
      vt[8]  = '{OP_REM,    MINV,           32'hFFFF_FFFF, 32'h0};
      vt[9]  = '{OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF};
      vt[10] = '{OP_REMU,   32'd5,          32'd0,         32'd5};
      vt[11] = '{OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF};
      vt[12] = '{OP_REM,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB};
      vt[13] = '{OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};
      vt[14] = '{OP_MUL,    32'h0001_0000,  32'h0001_0000, 32'h0};
      vt[15] = '{OP_DIVU,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1};

      rst = 1'b1; Start = 1'b0; MDControl = '0; SrcA = '0; SrcB = '0;
      @(negedge clk); @(negedge clk);
      chk("rst_busy", {63'b0, Busy}, 64'd0);
      chk("rst_done", {63'b0, Done}, 64'd0);
      chk("rst_result", {32'b0, MDResult}, 64'd0);
      chk("rst_zero", {63'b0, ZeroFlag}, 64'd1);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         run_op(vt[i].op, vt[i].a, vt[i].b, res, lat, zf, busy1);
         $display("vec %0d op=%0d a=%h b=%h res=%h lat=%0d", i, vt[i].op, vt[i].a, vt[i].b, res, lat);
         chk($sformatf("vec%0d_result", i), {32'b0, res}, {32'b0, vt[i].exp});
         chk($sformatf("vec%0d_zero", i), {63'b0, zf}, {63'b0, (vt[i].exp == 0)});
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat(vt[i].op, vt[i].a, vt[i].b)));
         if (lat > 1) chk($sformatf("vec%0d_busy", i), {63'b0, busy1}, 64'd1);
         @(posedge clk); @(negedge clk);
         chk($sformatf("vec%0d_pulse", i), {63'b0, Done}, 64'd0);
         chk($sformatf("vec%0d_hold", i), {32'b0, MDResult}, {32'b0, vt[i].exp});
      end

      // Start while busy must be ignored.
      MDControl = OP_MUL; SrcA = 32'd7; SrcB = 32'hFFFF_FFFD; Start = 1'b1;
      @(posedge clk); @(negedge clk);
      Start = 1'b0; ndone = 0; first = 0; res = '0;
      for (int cyc = 1; cyc <= 80; cyc++) begin
         if (cyc == 10) begin
            Start = 1'b1; MDControl = OP_DIVU; SrcA = 32'd100; SrcB = 32'd7;
         end else begin
            Start = 1'b0;
         end
         if (Done) begin
            ndone++;
            if (first == 0) begin first = cyc; res = MDResult; end
         end
         @(posedge clk); @(negedge clk);
      end
      $display("busy_start dones=%0d first=%0d res=%h", ndone, first, res);
      chk("busy_ndone", 64'(ndone), 64'd1);
      chk("busy_cycle", 64'(first), 64'd33);
      chk("busy_result", {32'b0, res}, 64'h0000_0000_FFFF_FFEB);

      // Back-to-back: second Start issued in the DONE cycle.
      run_op(OP_DIVU, 32'd100, 32'd7, res, lat, zf, busy1);
      run_op(OP_REMU, 32'd100, 32'd7, res2, lat2, zf, busy1);
      $display("b2b res1=%h res2=%h gap=%0d", res, res2, lat2);
      chk("b2b_res1", {32'b0, res}, 64'd14);
      chk("b2b_res2", {32'b0, res2}, 64'd2);
      chk("b2b_gap", 64'(lat2), 64'd33);
      @(posedge clk); @(negedge clk);

      // Reset mid-CALC aborts; a later op still completes.
      MDControl = OP_MUL; SrcA = 32'd9; SrcB = 32'd9; Start = 1'b1;
      @(posedge clk); @(negedge clk);
      Start = 1'b0;
      for (int cyc = 1; cyc < 15; cyc++) begin @(posedge clk); @(negedge clk); end
      rst = 1'b1;
      #1;
      chk("midrst_busy", {63'b0, Busy}, 64'd0);
      chk("midrst_result", {32'b0, MDResult}, 64'd0);
      chk("midrst_done", {63'b0, Done}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int cyc = 0; cyc < 50; cyc++) begin
         if (Done) ndone++;
         @(posedge clk); @(negedge clk);
      end
      $display("midrst dones_after=%0d", ndone);
      chk("midrst_nodone", 64'(ndone), 64'd0);
      run_op(OP_MUL, 32'd9, 32'd9, res, lat, zf, busy1);
      $display("post_rst res=%h lat=%0d", res, lat);
      chk("postrst_result", {32'b0, res}, 64'd81);
      chk("postrst_latency", 64'(lat), 64'd33);

      // Randomized ops, issued back-to-back.
      for (int i = 0; i < 200; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = rnd_operand();
         b  = rnd_operand();
         run_op(op, a, b, res, lat, zf, busy1);
         expv = ref_model(op, a, b);
         $display("rnd %0d op=%0d a=%h b=%h res=%h exp=%h", i, op, a, b, res, expv);
         chk($sformatf("rnd%0d_result", i), {32'b0, res}, {32'b0, expv});
         chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(exp_lat(op, a, b)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width; legal values are even and >= 4.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port Start  input  1  request; sampled only when the unit is accepting.
REQ-005 SHALL have port MDControl  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port SrcA  input  DATA_WIDTH  rs1 operand (multiplicand/dividend).
REQ-007 SHALL have port SrcB  input  DATA_WIDTH  rs2 operand (multiplier/divisor).
REQ-008 SHALL have port Busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port Done  output  1  one-cycle pulse; MDResult is valid for the new op in that cycle.
REQ-010 SHALL have port MDResult  output  DATA_WIDTH  registered result; holds its value until the next Done.
REQ-011 SHALL have port ZeroFlag  output  1  (MDResult == 0), combinational from MDResult.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE; Busy = (state == CALC); Done = (state == DONE).
REQ-013 SHALL accept Start in IDLE or DONE only; Start while in CALC SHALL be ignored with no effect.
REQ-014 On acceptance SHALL latch MDControl, SrcA, SrcB, operand signs and absolute values (signedness per op), then enter CALC.
REQ-015 CALC SHALL run exactly DATA_WIDTH iterations, one per cycle, using a down-counter of clog2(DATA_WIDTH)+1 bits.
REQ-016 Multiply SHALL use iterative shift-add into a 2*DATA_WIDTH product; divide SHALL use restoring shift-subtract yielding a quotient and a remainder.
REQ-017 The final sign fix-up SHALL be applied on exit from CALC: product negated if the operand signs differ; quotient negated if the signs differ; remainder takes the dividend's sign.
REQ-018 Results SHALL be: MUL = product[DATA_WIDTH-1:0]; MULH/MULHSU/MULHU = product[2*DATA_WIDTH-1:DATA_WIDTH].
REQ-019 Latency: Start accepted in cycle 0 SHALL give Done high in cycle DATA_WIDTH+1 (cycle 33 at the default); throughput is one op per DATA_WIDTH+1 cycles.
REQ-020 Start high in the DONE cycle SHALL be accepted, giving back-to-back operation; otherwise DONE SHALL return to IDLE.
REQ-021 Divide by zero SHALL give: DIV/DIVU = all ones; REM/REMU = SrcA.
REQ-022 Signed overflow (SrcA = most negative, SrcB = -1) SHALL give: DIV = most negative; REM = 0.
REQ-023 MDResult SHALL update only on the transition into DONE.

Reset
REQ-024 On rst high SHALL immediately force state IDLE, Busy=0, Done=0, MDResult=0, counter=0, and clear all internal datapath registers.
REQ-025 Reset mid-CALC SHALL abort the operation; no Done SHALL follow after reset is released.
REQ-026 After reset release SHALL accept Start on the first rising edge.

Configuration
REQ-027 Macro MULDIV_FAST_SPECIAL_EN SHALL control the early-out path for special cases.
REQ-028 With MULDIV_FAST_SPECIAL_EN defined, divide-by-zero and signed-overflow ops SHALL skip CALC and go IDLE->DONE, giving Done in cycle 1.
REQ-029 Without the macro, these cases SHALL take the full DATA_WIDTH+1 latency; result values per REQ-021/REQ-022 are identical either way.

Verification
REQ-030 Reset, then Start MUL with SrcA=7, SrcB=-3 (0xFFFFFFFD) -> Done in cycle 33, MDResult=0xFFFFFFEB, ZeroFlag=0.
REQ-031 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> MDResult=0xFFFFFFFE; MULH with the same operands -> 0x00000000, ZeroFlag=1.
REQ-032 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-033 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; Done in cycle 1 with the macro, cycle 33 without.
REQ-034 Start pulsed in cycle 10 while Busy -> ignored: exactly one Done, with the original op's result; Start in the DONE cycle -> second Done exactly 33 cycles later.
REQ-035 rst asserted mid-CALC at cycle 15 -> Busy=0 and MDResult=0 immediately; no Done; next Start completes normally.
